// File: rtl/axi_lite_cmd_master.sv
// AXI-lite command master: turns one command at a time into a single AXI-lite
// read or write and returns its response with a saturating cycle count.
module axi_lite_cmd_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [15:0]         rsp_latency,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] WR_RESP      = 3'd2;
    localparam logic [2:0] RD_ADDR      = 3'd3;
    localparam logic [2:0] RD_DATA      = 3'd4;
    localparam logic [2:0] RSP          = 3'd5;

    logic [2:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic [15:0]       lat_q, lat_d, lat_inc;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              arvalid_q, arvalid_d;
    logic              accept;

    // Gated with rstn so the master never looks ready while held in reset.
    assign cmd_ready = rstn && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign lat_inc   = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        lat_d     = lat_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    lat_d   = 16'd0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                lat_d = lat_inc;
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                // AW and W retire independently; leave once both have handshaken.
                if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                lat_d = lat_inc;
                if (m_bvalid) begin
                    resp_d  = m_bresp;
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                lat_d = lat_inc;
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                lat_d = lat_inc;
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    resp_d  = m_rresp;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            lat_q     <= 16'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            lat_q     <= lat_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign m_awvalid   = awvalid_q;
    assign m_awaddr    = addr_q;
    assign m_wvalid    = wvalid_q;
    assign m_wdata     = wdata_q;
    assign m_wstrb     = wstrb_q;
    assign m_bready    = (state_q == WR_RESP);
    assign m_arvalid   = arvalid_q;
    assign m_araddr    = addr_q;
    assign m_rready    = (state_q == RD_DATA);
    assign rsp_valid   = (state_q == RSP);
    // Read data is only captured on reads, so writes report zero here.
    assign rsp_rdata   = write_q ? '0 : rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_latency = lat_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: configurable-delay AXI-lite slave,
// expected responses queued at issue time and checked when the DUT responds.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [15:0]   rsp_latency;
    logic          m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata, m_rdata = '0;
    logic [3:0]    m_wstrb;
    logic          m_bvalid = 1'b0, m_bready, m_arvalid, m_arready = 1'b0;
    logic          m_rvalid = 1'b0, m_rready;
    logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [15:0] lat;
    } exp_t;
    exp_t sb[$];

    int n_pass = 0, n_fail = 0, n_total = 0;

    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [31:0] r_data_cfg = '0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0, last_araddr = '0;
    logic [3:0]  last_wstrb = '0;
    logic prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_arv = 0, prev_arr = 0;
    logic [31:0] prev_awaddr = '0, prev_araddr = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: each ready/valid rises after its configured number of waiting cycles,
    // stays up for exactly one cycle (the handshake cycle), then drops.
    always @(negedge clk) begin
        if (!rstn) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (m_awready) begin m_awready = 0; aw_cnt = 0; end
            else if (m_awvalid) begin if (aw_cnt >= aw_dly) m_awready = 1; else aw_cnt++; end
            if (m_wready) begin m_wready = 0; w_cnt = 0; end
            else if (m_wvalid) begin if (w_cnt >= w_dly) m_wready = 1; else w_cnt++; end
            if (m_arready) begin m_arready = 0; ar_cnt = 0; end
            else if (m_arvalid) begin if (ar_cnt >= ar_dly) m_arready = 1; else ar_cnt++; end
            if (m_bvalid) begin m_bvalid = 0; b_cnt = 0; end
            else if (m_bready) begin
                if (b_cnt >= b_dly) begin m_bvalid = 1; m_bresp = b_resp_cfg; end
                else b_cnt++;
            end
            if (m_rvalid) begin m_rvalid = 0; r_cnt = 0; end
            else if (m_rready) begin
                if (r_cnt >= r_dly) begin m_rvalid = 1; m_rdata = r_data_cfg; m_rresp = r_resp_cfg; end
                else r_cnt++;
            end
        end
    end

    // Channel monitor, sampled late in each cycle: handshake counts and valid/addr hold.
    always @(negedge clk) begin
        #3;
        if (!rstn) begin
            prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_arv = 0; prev_arr = 0;
        end else begin
            if (prev_awv && !prev_awr) chk("aw_hold", {m_awvalid, m_awaddr}, {1'b1, prev_awaddr});
            if (prev_wv && !prev_wr)   chk("w_hold", m_wvalid, 1);
            if (prev_arv && !prev_arr) chk("ar_hold", {m_arvalid, m_araddr}, {1'b1, prev_araddr});
            if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; end
            if (m_wvalid && m_wready) begin w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb; end
            if (m_bvalid && m_bready) b_hs++;
            if (m_arvalid && m_arready) begin ar_hs++; last_araddr = m_araddr; end
            if (m_rvalid && m_rready) r_hs++;
            prev_awv = m_awvalid; prev_awr = m_awready; prev_awaddr = m_awaddr;
            prev_wv = m_wvalid; prev_wr = m_wready;
            prev_arv = m_arvalid; prev_arr = m_arready; prev_araddr = m_araddr;
        end
    end

    task automatic clear_counts();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rst_ctrl", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}, 7'b0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_latency}, 50'b0);
        chk("rst_cmdregs", {m_awaddr, m_wdata, m_wstrb}, 68'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b1;
        #1 chk("rst_release_ready", cmd_ready, 1);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        // Scramble the command bus right after accept; the DUT must not care.
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~data; cmd_wstrb = ~strb;
    endtask

    task automatic get_rsp(input string tag);
        int n;
        exp_t e;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, rsp_valid, 1);
        if (rsp_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_resp"}, rsp_resp, e.resp);
            chk({tag, "_latency"}, rsp_latency, e.lat);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int snap;
        do_reset();

        // zero-wait write: latency 2
        clear_counts();
        issue(1'b1, 32'h14, 32'h1, 4'hF);
        sb.push_back('{rdata: 32'h0, resp: 2'b00, lat: 16'd2});
        get_rsp("wr0");
        chk("wr0_beats", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, {8'd1, 8'd1, 8'd1});
        chk("wr0_aw_w", {last_awaddr, last_wdata, last_wstrb}, {32'h14, 32'h1, 4'hF});

        // read: arready after 3 waiting cycles, rvalid 2 cycles later -> latency 2+3+2
        clear_counts();
        ar_dly = 3; r_dly = 2; r_data_cfg = 32'hDEADBEEF;
        issue(1'b0, 32'h0, 32'h0, 4'h0);
        sb.push_back('{rdata: 32'hDEADBEEF, resp: 2'b00, lat: 16'd7});
        get_rsp("rd0");
        chk("rd0_beats", {ar_hs[7:0], r_hs[7:0], aw_hs[7:0]}, {8'd1, 8'd1, 8'd0});
        chk("rd0_araddr", last_araddr, 32'h0);

        // split write: W completes first, AW waits 4 cycles
        clear_counts();
        ar_dly = 0; r_dly = 0; aw_dly = 4; w_dly = 0; b_dly = 0;
        issue(1'b1, 32'h100, 32'hCAFEF00D, 4'h3);
        @(negedge clk);
        @(negedge clk);
        chk("split_mid", {m_wvalid, m_awvalid, w_hs[7:0], aw_hs[7:0]}, {1'b0, 1'b1, 8'd1, 8'd0});
        sb.push_back('{rdata: 32'h0, resp: 2'b00, lat: 16'd6});
        get_rsp("split");
        chk("split_beats", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, {8'd1, 8'd1, 8'd1});
        chk("split_aw_w", {last_awaddr, last_wdata, last_wstrb}, {32'h100, 32'hCAFEF00D, 4'h3});

        // AW first, W after 2, B after 3 -> latency 2+2+3
        clear_counts();
        aw_dly = 0; w_dly = 2; b_dly = 3;
        issue(1'b1, 32'h8, 32'h0BADF00D, 4'hC);
        sb.push_back('{rdata: 32'h0, resp: 2'b00, lat: 16'd7});
        get_rsp("awfirst");
        chk("awfirst_beats", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, {8'd1, 8'd1, 8'd1});

        // backpressure: hold response 10 cycles with a read offered meanwhile
        clear_counts();
        w_dly = 0; b_dly = 0;
        issue(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
        sb.push_back('{rdata: 32'h0, resp: 2'b00, lat: 16'd2});
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("bp_rsp_seen", rsp_valid, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
        r_data_cfg = 32'h12345678;
        sb.push_back('{rdata: 32'h12345678, resp: 2'b00, lat: 16'd2});
        snap = aw_hs + w_hs + b_hs + ar_hs + r_hs;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, cmd_ready, rsp_latency, rsp_resp, rsp_rdata,
                            m_awvalid, m_wvalid, m_arvalid, aw_hs + w_hs + b_hs + ar_hs + r_hs},
                           {1'b1, 1'b0, 16'd2, 2'b00, 32'h0, 3'b000, snap});
        end
        get_rsp("bp_wr");
        chk("bp_ready_after", {cmd_ready, ar_hs[7:0]}, {1'b1, 8'd0});
        @(negedge clk);
        cmd_valid = 1'b0;
        get_rsp("bp_rd");
        chk("bp_rd_ar", {ar_hs[7:0], last_araddr}, {8'd1, 32'h40});

        // error responses reported verbatim
        b_resp_cfg = 2'b10;
        issue(1'b1, 32'h30, 32'h3, 4'h1);
        sb.push_back('{rdata: 32'h0, resp: 2'b10, lat: 16'd2});
        get_rsp("slverr");
        b_resp_cfg = 2'b00;
        ar_dly = 1; r_resp_cfg = 2'b11; r_data_cfg = 32'h55;
        issue(1'b0, 32'h34, 32'h0, 4'h0);
        sb.push_back('{rdata: 32'h55, resp: 2'b11, lat: 16'd3});
        get_rsp("decerr");
        ar_dly = 0; r_resp_cfg = 2'b00;

        // timeout: B never arrives, counter saturates, master keeps waiting
        b_dly = 1000000;
        issue(1'b1, 32'h50, 32'h5, 4'hF);
        repeat (70000) @(negedge clk);
        chk("timeout", {rsp_latency, rsp_valid, m_bready}, {16'hFFFF, 1'b0, 1'b1});
        do_reset();
        b_dly = 0;

        // reset while waiting in RD_DATA abandons the read
        r_dly = 1000000;
        issue(1'b0, 32'h60, 32'h0, 4'h0);
        @(negedge clk);
        chk("rd_wait_rready", m_rready, 1);
        do_reset();
        r_dly = 0;
        repeat (5) @(negedge clk);
        chk("no_rsp_after_rst", rsp_valid, 0);

        // recovery read after the abandoned one
        r_data_cfg = 32'h77;
        issue(1'b0, 32'h64, 32'h0, 4'h0);
        sb.push_back('{rdata: 32'h77, resp: 2'b00, lat: 16'd2});
        get_rsp("recover");

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
